// File: rtl/alu_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// alu_seq_ctrl : execute-stage sequencer that drives an external 8-bit ALU
// Revision     : 1.0
// ============================================================================
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       carry_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_acc;
  logic [7:0] r_opnd;
  logic [2:0] r_op;
  logic       r_c;
  logic       r_z;
  logic       r_load;
  logic       r_cmd_ready;
  logic       r_res_valid;
  logic       r_busy;
  logic       w_cmd_fire;

  assign w_cmd_fire = r_cmd_ready & cmd_valid;

  assign cmd_ready = r_cmd_ready;
  assign res_valid = r_res_valid;
  assign busy      = r_busy;
  assign res_data  = r_acc;
  assign res_carry = r_c;
  assign res_zero  = r_z;
  assign alu_a     = r_acc;
  assign alu_b     = r_opnd;
  assign alu_sel   = r_op;

  // cmd_ready is a register so it reads 0 throughout reset; it rises on the
  // first edge after release while sitting in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= 8'h00;
      r_opnd      <= 8'h00;
      r_op        <= 3'd0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_load      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            r_op        <= cmd_op;
            r_opnd      <= cmd_operand;
            r_load      <= cmd_load;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_load) begin
              r_acc       <= cmd_operand;
              r_z         <= (cmd_operand == 8'h00);
              r_res_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Loads never reach ISSUE; steering one straight to RESP keeps the
          // accumulator untouched should that ever happen.
          if (r_load) begin
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_state     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_acc       <= alu_out;
          r_c         <= carry_out;
          r_z         <= (alu_out == 8'h00);
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_alu_seq_ctrl : scoreboard bench for alu_seq_ctrl with a behavioural ALU
// Revision        : 1.0
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       z;
  } resp_t;

  resp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_acc;
  logic       m_c;
  logic       m_z;
  logic [7:0] last_a;
  logic [7:0] last_b;
  logic [2:0] last_op;
  logic       last_load;
  logic [7:0] last_d;
  logic       last_c;
  logic       last_z;

  alu_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .carry_out   (carry_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_carry   (res_carry),
    .res_zero    (res_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result}
  function automatic logic [8:0] alu_model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a < b), a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a[7], a << 1};
      3'd6:    return {a[0], a >> 1};
      default: return {1'b0, ~a};
    endcase
  endfunction

  always_comb begin
    {carry_out, alu_out} = alu_model(alu_sel, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result and command handshakes must never be offered together.
  always @(negedge clk) begin
    if (!rst) check("ready_valid_exclusive", {31'd0, res_valid & cmd_ready}, 32'd0);
  end

  task automatic send(input logic load, input logic [2:0] op, input logic [7:0] opnd, output int waited);
    logic [8:0] r9;
    resp_t      e;
    cmd_valid   = 1'b1;
    cmd_load    = load;
    cmd_op      = op;
    cmd_operand = opnd;
    waited      = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    last_a    = m_acc;
    last_b    = opnd;
    last_op   = op;
    last_load = load;
    if (load) begin
      m_acc = opnd;
      m_z   = (opnd == 8'h00);
    end else begin
      r9    = alu_model(op, m_acc, opnd);
      m_acc = r9[7:0];
      m_c   = r9[8];
      m_z   = (r9[7:0] == 8'h00);
    end
    e.d = m_acc;
    e.c = m_c;
    e.z = m_z;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic recv(input int stall);
    int    lat;
    resp_t e;
    lat = 1;
    @(negedge clk);
    if (!last_load) begin
      check("issue_alu_a", {24'd0, alu_a}, {24'd0, last_a});
      check("issue_alu_b", {24'd0, alu_b}, {24'd0, last_b});
      check("issue_alu_sel", {29'd0, alu_sel}, {29'd0, last_op});
      check("issue_busy", {31'd0, busy}, 32'd1);
      check("issue_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("res_latency", lat, last_load ? 32'd1 : 32'd3);
    check("sb_depth", sb.size(), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check("res_data", {24'd0, res_data}, {24'd0, e.d});
    check("res_carry", {31'd0, res_carry}, {31'd0, e.c});
    check("res_zero", {31'd0, res_zero}, {31'd0, e.z});
    last_d = res_data;
    last_c = res_carry;
    last_z = res_zero;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_res_data", {24'd0, res_data}, {24'd0, e.d});
      check("stall_res_flags", {30'd0, res_carry, res_zero}, {30'd0, e.c, e.z});
      check("stall_res_valid", {31'd0, res_valid}, 32'd1);
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("post_res_valid", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0; cmd_operand = 8'h00; res_ready = 1'b0;
    m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {res_valid, cmd_ready, busy, res_carry, res_zero, res_data, alu_a, alu_b, alu_sel},
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Load then add 0x6F + 0x6F
    send(1'b1, 3'd0, 8'h6F, w); recv(0);
    check("t2_load_data", {24'd0, last_d}, 32'h6F);
    check("t2_load_zero", {31'd0, last_z}, 32'd0);
    send(1'b0, 3'd0, 8'h6F, w); recv(0);
    check("t2_add", {23'd0, last_c, last_d, last_z}, {23'd0, 1'b0, 8'hDE, 1'b0});

    // 0xFF + 0x01 wraps to zero with carry
    send(1'b1, 3'd0, 8'hFF, w); recv(0);
    send(1'b0, 3'd0, 8'h01, w); recv(0);
    check("t3_add_wrap", {23'd0, last_c, last_d, last_z}, {23'd0, 1'b1, 8'h00, 1'b1});

    // Load zero keeps C
    send(1'b1, 3'd0, 8'h00, w); recv(0);
    check("t4_load_zero", {23'd0, last_c, last_d, last_z}, {23'd0, 1'b1, 8'h00, 1'b1});

    // Response stall with next command waiting
    send(1'b1, 3'd0, 8'h30, w);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd1; cmd_operand = 8'h10;
    recv(5);
    check("t5_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send(1'b0, 3'd1, 8'h10, w);
    check("t5_accept_wait", w, 32'd0);
    recv(0);
    check("t5_sub", {23'd0, last_c, last_d, last_z}, {23'd0, 1'b0, 8'h20, 1'b0});

    // Reset in the middle of a pending response
    send(1'b1, 3'd0, 8'hA5, w);
    check("t1_pending_valid", {31'd0, res_valid}, 32'd1);
    check("t1_pending_data", {24'd0, res_data}, 32'hA5);
    #2 rst = 1'b1;
    #1;
    check("t1_async_clear", {res_valid, busy, cmd_ready, res_carry, res_zero, res_data}, 32'd0);
    sb.delete();
    m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t1_no_stale_resp", {31'd0, res_valid}, 32'd0);
    end
    check("t1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send(1'b0, 3'd0, 8'h00, w); recv(0);
    check("t1_flags_cleared", {23'd0, last_c, last_d, last_z}, {23'd0, 1'b0, 8'h00, 1'b1});

    // Sweep every select with A = B = 0x6F
    for (int op = 0; op < 8; op++) begin
      send(1'b1, 3'd0, 8'h6F, w); recv(0);
      send(1'b0, op[2:0], 8'h6F, w); recv(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
